video_mixer: RTL and testbench

- Pixel compositor directly downstream of the sprite engines and playfield generator; sits just before the video DAC/output pins.
- Per pixel strobe it samples the 1-bit sprite and playfield pixels and resolves priority to an 8-bit RRRGGGBB colour from CPU-programmable palette registers.
- It latches sprite/sprite and sprite/playfield collisions for the CPU, and delays hsync/vsync to stay aligned with the colour output.

---
 rtl/video_mixer.sv | 170 +++++++++++++++++
 tb/tb_video_mixer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_mixer.sv
// Pixel compositor: resolves sprite/playfield priority to an RRRGGGBB palette colour,
// latches collisions for the CPU, and delays syncs to stay aligned with rgb (2-stage pipe).
module video_mixer #(
  parameter int NSPR = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            rw,
  input  logic [3:0]      addr,
  input  logic [7:0]      di,
  output logic [7:0]      dout,
  input  logic            pix_en,
  input  logic [NSPR-1:0] spr_pix,
  input  logic            pf_pix,
  input  logic            blank,
  input  logic            hsync,
  input  logic            vsync,
  output logic [7:0]      rgb,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic            irq
);

  logic [7:0]            bg_q, bg_d, pf_q, pf_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic [NSPR-1:0][7:0]  spr_col_q, spr_col_d;
  logic [NSPR-1:0]       ss_q, ss_d, sp_q, sp_d;
  logic [7:0]            dout_q, dout_d;
  logic                  irq_q, irq_d;

  logic [NSPR-1:0]       spr1_q, spr1_d;
  logic                  pf1_q, pf1_d, blank1_q, blank1_d;
  logic                  hs1_q, hs1_d, vs1_q, vs1_d, v1_q;
  logic [7:0]            rgb_q, rgb_d;
  logic                  hs_q, hs_d, vs_q, vs_d;

  logic                  wr, rd;
  logic [7:0]            rdata, col, spr_c;
  logic                  spr_hit;
  logic [NSPR-1:0]       ss_set, sp_set, others;

  assign wr = cs & rw;
  assign rd = cs & ~rw;

  always_comb begin
    bg_d      = bg_q;
    pf_d      = pf_q;
    ctrl_d    = ctrl_q;
    spr_col_d = spr_col_q;
    if (wr) begin
      case (addr)
        4'd0:    bg_d   = di;
        4'd1:    pf_d   = di;
        4'd2:    ctrl_d = di[1:0];
        default: ;
      endcase
      for (int i = 0; i < NSPR; i++)
        if (addr == 4'(8 + i)) spr_col_d[i] = di;
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (addr)
      4'd0:    rdata = bg_q;
      4'd1:    rdata = pf_q;
      4'd2:    rdata = {6'b0, ctrl_q};
      4'd3:    rdata = 8'(ss_q);
      4'd4:    rdata = 8'(sp_q);
      default: ;
    endcase
    for (int i = 0; i < NSPR; i++)
      if (addr == 4'(8 + i)) rdata = spr_col_q[i];
    dout_d = rd ? rdata : dout_q;
  end

  // Walk downwards so the lowest-index active sprite wins.
  always_comb begin
    spr_hit = 1'b0;
    spr_c   = 8'h00;
    for (int i = NSPR - 1; i >= 0; i--)
      if (spr1_q[i]) begin
        spr_hit = 1'b1;
        spr_c   = spr_col_q[i];
      end
    if (blank1_q)              col = 8'h00;
    else if (ctrl_q[0] && pf1_q) col = pf_q;
    else if (spr_hit)          col = spr_c;
    else if (pf1_q)            col = pf_q;
    else                       col = bg_q;
  end

  always_comb begin
    ss_set = '0;
    others = '0;
    for (int i = 0; i < NSPR; i++) begin
      others    = spr1_q;
      others[i] = 1'b0;
      ss_set[i] = spr1_q[i] & (|others);
    end
    sp_set = spr1_q & {NSPR{pf1_q}};
    if (!(v1_q && !blank1_q)) begin
      ss_set = '0;
      sp_set = '0;
    end
    // Clearing read and a fresh set on the same edge: the fresh bits survive.
    ss_d  = ((rd && addr == 4'd3) ? '0 : ss_q) | ss_set;
    sp_d  = ((rd && addr == 4'd4) ? '0 : sp_q) | sp_set;
    irq_d = ctrl_d[1] & ((|ss_d) | (|sp_d));
  end

  always_comb begin
    spr1_d   = pix_en ? spr_pix : spr1_q;
    pf1_d    = pix_en ? pf_pix  : pf1_q;
    blank1_d = pix_en ? blank   : blank1_q;
    hs1_d    = pix_en ? hsync   : hs1_q;
    vs1_d    = pix_en ? vsync   : vs1_q;
    rgb_d    = v1_q ? col   : rgb_q;
    hs_d     = v1_q ? hs1_q : hs_q;
    vs_d     = v1_q ? vs1_q : vs_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bg_q      <= '0;
      pf_q      <= '0;
      ctrl_q    <= '0;
      spr_col_q <= '0;
      ss_q      <= '0;
      sp_q      <= '0;
      dout_q    <= '0;
      irq_q     <= 1'b0;
      spr1_q    <= '0;
      pf1_q     <= 1'b0;
      blank1_q  <= 1'b0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      v1_q      <= 1'b0;
      rgb_q     <= '0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      bg_q      <= bg_d;
      pf_q      <= pf_d;
      ctrl_q    <= ctrl_d;
      spr_col_q <= spr_col_d;
      ss_q      <= ss_d;
      sp_q      <= sp_d;
      dout_q    <= dout_d;
      irq_q     <= irq_d;
      spr1_q    <= spr1_d;
      pf1_q     <= pf1_d;
      blank1_q  <= blank1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      v1_q      <= pix_en;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign dout    = dout_q;
  assign irq     = irq_q;
  assign rgb     = rgb_q;
  assign hsync_o = hs_q;
  assign vsync_o = vs_q;

endmodule

// File: tb/tb_video_mixer.sv
// Directed register/priority/collision checks followed by a randomized pixel stream
// compared against a behavioural model of the compositor.
module tb_video_mixer;
  localparam int NSPR = 2;

  logic            clk = 1'b0;
  logic            reset, cs, rw, pix_en, pf_pix, blank, hsync, vsync;
  logic [3:0]      addr;
  logic [7:0]      di, dout, rgb;
  logic [NSPR-1:0] spr_pix;
  logic            hsync_o, vsync_o, irq;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  video_mixer #(.NSPR(NSPR)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rw(rw), .addr(addr), .di(di), .dout(dout),
    .pix_en(pix_en), .spr_pix(spr_pix), .pf_pix(pf_pix), .blank(blank),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Model state
  logic [7:0]      m_bg, m_pf;
  logic [7:0]      m_sc [NSPR];
  logic            m_front, m_irqen;
  logic [NSPR-1:0] exp_ss, exp_sp;
  logic [7:0]      exp_rgb;
  logic            exp_hs, exp_vs, exp_irq;

  typedef struct {
    int              due;
    logic [NSPR-1:0] spr;
    logic            pf, bl, hs, vs;
  } pix_t;
  pix_t q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b1; addr = a; di = d;
    step();
    cs = 1'b0; rw = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    cs = 1'b1; rw = 1'b0; addr = a;
    step();
    cs = 1'b0;
    d = dout;
  endtask

  task automatic pix(input logic [NSPR-1:0] s, input logic p, input logic b,
                     input logic h, input logic v);
    pix_en = 1'b1; spr_pix = s; pf_pix = p; blank = b; hsync = h; vsync = v;
    step();
    pix_en = 1'b0;
    step();
  endtask

  function automatic logic [7:0] resolve(input logic [NSPR-1:0] s, input logic p,
                                         input logic b);
    int lowest;
    lowest = -1;
    for (int i = NSPR - 1; i >= 0; i--) if (s[i]) lowest = i;
    if (b) return 8'h00;
    if (m_front && p) return m_pf;
    if (lowest >= 0) return m_sc[lowest];
    if (p) return m_pf;
    return m_bg;
  endfunction

  // One clock, then retire any pixel whose output is due on this edge.
  task automatic mstep();
    pix_t e;
    step();
    if (q.size() > 0 && q[0].due == edge_n) begin
      e = q.pop_front();
      exp_rgb = resolve(e.spr, e.pf, e.bl);
      exp_hs  = e.hs;
      exp_vs  = e.vs;
      if (!e.bl) begin
        if ($countones(e.spr) >= 2) exp_ss = exp_ss | e.spr;
        if (e.pf) exp_sp = exp_sp | e.spr;
      end
    end
    exp_irq = m_irqen && ((exp_ss | exp_sp) != '0);
  endtask

  logic [7:0] d;
  pix_t e;

  initial begin
    reset = 1'b1; cs = 1'b0; rw = 1'b0; addr = '0; di = '0;
    pix_en = 1'b0; spr_pix = '1; pf_pix = 1'b1; blank = 1'b0; hsync = 1'b1; vsync = 1'b1;

    // Reset with strobes toggling
    for (int i = 0; i < 4; i++) begin
      pix_en = ~pix_en;
      step();
      chk("rst_rgb", rgb, 8'h00);
      chk("rst_hs", {7'b0, hsync_o}, 8'h00);
      chk("rst_vs", {7'b0, vsync_o}, 8'h00);
      chk("rst_irq", {7'b0, irq}, 8'h00);
      chk("rst_dout", dout, 8'h00);
    end
    reset = 1'b0; pix_en = 1'b0; hsync = 1'b0; vsync = 1'b0;
    for (int a = 0; a < 5; a++) begin
      rd(4'(a), d);
      chk($sformatf("rst_reg%0d", a), d, 8'h00);
    end

    // Palette and priority
    wr(4'd0, 8'h03); wr(4'd1, 8'h1C); wr(4'd8, 8'hE0); wr(4'd9, 8'h55); wr(4'd2, 8'h00);
    pix(2'b01, 1'b1, 1'b0, 1'b0, 1'b0); chk("prio_spr_back", rgb, 8'hE0);
    wr(4'd2, 8'h01);
    pix(2'b01, 1'b1, 1'b0, 1'b0, 1'b0); chk("prio_pf_front", rgb, 8'h1C);
    pix(2'b00, 1'b0, 1'b0, 1'b0, 1'b0); chk("prio_bg", rgb, 8'h03);
    wr(4'd2, 8'h00);
    pix(2'b10, 1'b0, 1'b0, 1'b0, 1'b0); chk("prio_spr1", rgb, 8'h55);

    // Blank and sync alignment: nothing moves until the stage-2 edge
    pix_en = 1'b1; spr_pix = 2'b11; pf_pix = 1'b0; blank = 1'b1; hsync = 1'b1; vsync = 1'b1;
    step();
    pix_en = 1'b0;
    chk("sync_early_hs", {7'b0, hsync_o}, 8'h00);
    chk("sync_early_rgb", rgb, 8'h55);
    step();
    chk("blank_rgb", rgb, 8'h00);
    chk("blank_hs", {7'b0, hsync_o}, 8'h01);
    chk("blank_vs", {7'b0, vsync_o}, 8'h01);
    hsync = 1'b0; vsync = 1'b0; blank = 1'b0;
    rd(4'd3, d); chk("blank_no_ss", d, 8'h00);

    // Collision latching, clear-on-read and irq
    wr(4'd2, 8'h02);
    pix(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("coll_irq_set", {7'b0, irq}, 8'h01);
    rd(4'd3, d); chk("coll_ss", d, 8'h03);
    rd(4'd3, d); chk("coll_ss_cleared", d, 8'h00);
    chk("coll_irq_held", {7'b0, irq}, 8'h01);
    rd(4'd4, d); chk("coll_sp", d, 8'h03);
    chk("coll_irq_drop", {7'b0, irq}, 8'h00);

    // Read racing a fresh set
    pix(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    pix_en = 1'b1; spr_pix = 2'b01; pf_pix = 1'b1;
    step();
    pix_en = 1'b0;
    rd(4'd4, d); chk("race_old", d, 8'h02);
    chk("race_irq", {7'b0, irq}, 8'h01);
    rd(4'd4, d); chk("race_new", d, 8'h01);

    // Read-only and unmapped addresses
    wr(4'd3, 8'hFF); wr(4'd15, 8'hFF);
    rd(4'd3, d); chk("ro_ss", d, 8'h00);
    rd(4'd15, d); chk("unmapped", d, 8'h00);
    wr(4'd2, 8'hFF);
    rd(4'd2, d); chk("ctrl_mask", d, 8'h03);

    // Randomized stream against the model
    m_bg = 8'($urandom); m_pf = 8'($urandom);
    for (int i = 0; i < NSPR; i++) m_sc[i] = 8'($urandom);
    m_front = 1'($urandom); m_irqen = 1'($urandom);
    wr(4'd0, m_bg); wr(4'd1, m_pf);
    for (int i = 0; i < NSPR; i++) wr(4'(8 + i), m_sc[i]);
    pix(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    wr(4'd2, {6'b0, m_irqen, m_front});
    rd(4'd3, d); rd(4'd4, d);
    exp_ss = '0; exp_sp = '0; exp_rgb = 8'h00; exp_hs = 1'b0; exp_vs = 1'b0; exp_irq = 1'b0;
    for (int k = 0; k < 400; k++) begin
      pix_en  = 1'($urandom);
      spr_pix = NSPR'($urandom);
      pf_pix  = 1'($urandom);
      blank   = ($urandom_range(0, 3) == 0);
      hsync   = 1'($urandom);
      vsync   = 1'($urandom);
      if (pix_en) begin
        e.due = edge_n + 2; e.spr = spr_pix; e.pf = pf_pix;
        e.bl = blank; e.hs = hsync; e.vs = vsync;
        q.push_back(e);
      end
      mstep();
      chk("rnd_rgb", rgb, exp_rgb);
      chk("rnd_hs", {7'b0, hsync_o}, {7'b0, exp_hs});
      chk("rnd_vs", {7'b0, vsync_o}, {7'b0, exp_vs});
      chk("rnd_irq", {7'b0, irq}, {7'b0, exp_irq});
    end
    pix_en = 1'b0;
    mstep(); mstep();
    chk("rnd_rgb_tail", rgb, exp_rgb);
    rd(4'd3, d); chk("rnd_ss", d, 8'(exp_ss));
    rd(4'd4, d); chk("rnd_sp", d, 8'(exp_sp));

    // Reset while a pixel is in flight
    pix_en = 1'b1; spr_pix = 2'b01; pf_pix = 1'b1; blank = 1'b0; hsync = 1'b1;
    step();
    pix_en = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("midrst_rgb", rgb, 8'h00);
    chk("midrst_hs", {7'b0, hsync_o}, 8'h00);
    rd(4'd8, d); chk("midrst_pal", d, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
